// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and grey/binary pointer conversions.
// Functions work on 32-bit values; callers zero-extend and truncate to pointer width.
package fifo_pkg;
    localparam int FIFO_ADDR_W = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper grey bits decode to zero, so narrower pointers convert correctly.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: WIDTH x STAGES flop chain carrying a grey pointer across clock domains.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain pointer, empty/almost_empty/fill flags and underflow pulse
// of the asynchronous FIFO.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_grey,
    output logic              rd_fire,
    output logic [ADDR_W-1:0] rd_addr_bin,
    output logic [ADDR_W:0]   rd_addr_grey,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_fill,
    output logic              underflow
);
    localparam int PW = ADDR_W + 1;

    logic [ADDR_W:0] wr_sync;
    logic [ADDR_W:0] rd_bin_r;
    logic [ADDR_W:0] rd_bin_next;
    logic [ADDR_W:0] rd_grey_next;
    logic [ADDR_W:0] fill_next;

    ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_ptr_grey),
        .q   (wr_sync)
    );

    // Flags come from the next pointer so the draining read sets empty on its own edge.
    always_comb begin
        rd_fire      = rd_en & ~empty;
        rd_bin_next  = rd_bin_r + PW'(rd_fire);
        rd_grey_next = PW'(bin2gray(32'(rd_bin_next)));
        fill_next    = PW'(gray2bin(32'(wr_sync))) - rd_bin_next;
    end

    always_ff @(posedge rd_clk or posedge rd_rst)
        if (rd_rst) begin
            rd_bin_r     <= '0;
            rd_addr_grey <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_fill      <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_bin_r     <= rd_bin_next;
            rd_addr_grey <= rd_grey_next;
            empty        <= rd_grey_next == wr_sync;
            almost_empty <= fill_next <= PW'(AEMPTY_TH);
            rd_fill      <= fill_next;
            underflow    <= rd_en & empty;
        end

    assign rd_addr_bin = rd_bin_r[ADDR_W-1:0];
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed checks of the FIFO read controller (ADDR_W=4, 2 sync stages).
module tb_fifo_rd_ctrl;
    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] wr_ptr_grey = '0;
    logic       rd_fire;
    logic [3:0] rd_addr_bin;
    logic [4:0] rd_addr_grey;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_fill;
    logic       underflow;

    int total = 0;
    int bad = 0;

    fifo_rd_ctrl #(.ADDR_W(4), .SYNC_STAGES(2), .AEMPTY_TH(2)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .rd_en        (rd_en),
        .wr_ptr_grey  (wr_ptr_grey),
        .rd_fire      (rd_fire),
        .rd_addr_bin  (rd_addr_bin),
        .rd_addr_grey (rd_addr_grey),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_fill      (rd_fill),
        .underflow    (underflow)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({empty, almost_empty, rd_addr_bin, rd_addr_grey, rd_fill, underflow} !== {1'b1, 1'b1, 4'd0, 5'd0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL %s: empty=%b aempty=%b addr=%0d grey=%b fill=%0d uf=%b, want 1 1 0 00000 0 0",
                     tag, empty, almost_empty, rd_addr_bin, rd_addr_grey, rd_fill, underflow);
        end
    endtask

    task automatic do_reset();
        wr_ptr_grey = '0;
        rd_en = 1'b0;
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2 rd_rst = 1'b1;
        #1 check_reset_outputs("reset_no_clock");
        tick();
        tick();
        rd_rst = 1'b0;
        tick();
        tick();
        tick();
        check_reset_outputs("reset_release_idle");
    endtask

    task automatic test_fill_one();
        wr_ptr_grey = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total++;
            if (empty !== (e < 3)) begin
                bad++;
                $display("FAIL latency_edge%0d: empty=%b want %b", e, empty, e < 3);
            end
        end
        total++;
        if (rd_fill !== 5'd1 || almost_empty !== 1'b1) begin
            bad++;
            $display("FAIL fill_one: fill=%0d aempty=%b want 1 1", rd_fill, almost_empty);
        end
        rd_en = 1'b1;
        #1;
        total++;
        if (rd_fire !== 1'b1) begin
            bad++;
            $display("FAIL fire_one: rd_fire=%b want 1", rd_fire);
        end
        tick();
        rd_en = 1'b0;
        total++;
        if ({rd_addr_bin, rd_addr_grey, empty, rd_fill} !== {4'd1, 5'b00001, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL read_one: addr=%0d grey=%b empty=%b fill=%0d want 1 00001 1 0",
                     rd_addr_bin, rd_addr_grey, empty, rd_fill);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] want_fill;
        logic [3:0] want_addr;
        do_reset();
        wr_ptr_grey = 5'b11000;
        tick();
        tick();
        tick();
        total++;
        if ({rd_fill, empty, almost_empty} !== {5'd16, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full16: fill=%0d empty=%b aempty=%b want 16 0 0", rd_fill, empty, almost_empty);
        end
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            total++;
            if (rd_fire !== 1'b1) begin
                bad++;
                $display("FAIL b2b_fire%0d: rd_fire=%b want 1", i, rd_fire);
            end
            tick();
            want_fill = 5'(16 - i);
            want_addr = 4'(i);
            total++;
            if ({rd_fill, rd_addr_bin, almost_empty, empty} !== {want_fill, want_addr, 1'(16 - i <= 2), 1'(i == 16)}) begin
                bad++;
                $display("FAIL b2b_read%0d: fill=%0d addr=%0d aempty=%b empty=%b want %0d %0d %b %b",
                         i, rd_fill, rd_addr_bin, almost_empty, empty, want_fill, want_addr, 16 - i <= 2, i == 16);
            end
        end
        rd_en = 1'b0;
        total++;
        if (rd_addr_grey !== 5'b11000) begin
            bad++;
            $display("FAIL b2b_grey: grey=%b want 11000", rd_addr_grey);
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        #1;
        total++;
        if (rd_fire !== 1'b0) begin
            bad++;
            $display("FAIL uf_fire: rd_fire=%b want 0", rd_fire);
        end
        tick();
        rd_en = 1'b0;
        total++;
        if ({underflow, rd_addr_bin, rd_addr_grey, empty} !== {1'b1, 4'd0, 5'b11000, 1'b1}) begin
            bad++;
            $display("FAIL uf_pulse: uf=%b addr=%0d grey=%b empty=%b want 1 0 11000 1",
                     underflow, rd_addr_bin, rd_addr_grey, empty);
        end
        tick();
        total++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL uf_clear: uf=%b want 0", underflow);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] wr_m = 5'd16;
        logic [4:0] rd_m = 5'd16;
        logic [4:0] true_fill;
        logic       f;
        int writes = 0;
        int cycles = 0;
        bit wrapped = 0;
        while (writes < 40 && cycles < 600) begin
            cycles++;
            rd_en = 1'($urandom_range(0, 1));
            #1;
            f = rd_fire;
            if (f && wr_m == rd_m) begin
                total++;
                bad++;
                $display("FAIL wrap_read_unwritten: cycle %0d rd=%0d wr=%0d", cycles, rd_m, wr_m);
            end
            if (5'(wr_m - rd_m) < 5'd16 && $urandom_range(0, 2) != 0) begin
                wr_m = wr_m + 5'd1;
                if (wr_m == 5'd0) wrapped = 1;
                writes++;
                wr_ptr_grey = g(wr_m);
            end
            tick();
            if (f) rd_m = rd_m + 5'd1;
            true_fill = wr_m - rd_m;
            total++;
            if (rd_addr_bin !== rd_m[3:0] || rd_fill > true_fill || $isunknown(rd_fill)) begin
                bad++;
                $display("FAIL wrap_cycle%0d: addr=%0d fill=%0d want addr %0d fill<=%0d",
                         cycles, rd_addr_bin, rd_fill, rd_m[3:0], true_fill);
            end
        end
        rd_en = 1'b0;
        total++;
        if (writes < 40 || !wrapped) begin
            bad++;
            $display("FAIL wrap_budget: writes=%0d wrapped=%0d want 40 1", writes, wrapped);
        end
        tick();
        tick();
        tick();
        true_fill = wr_m - rd_m;
        total++;
        if ({rd_fill, empty, rd_addr_grey} !== {true_fill, 1'(true_fill == 0), g(rd_m)}) begin
            bad++;
            $display("FAIL wrap_settle: fill=%0d empty=%b grey=%b want %0d %b %b",
                     rd_fill, empty, rd_addr_grey, true_fill, true_fill == 0, g(rd_m));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr_ptr_grey = 5'b00100;
        tick();
        tick();
        tick();
        total++;
        if ({rd_fill, empty} !== {5'd7, 1'b0}) begin
            bad++;
            $display("FAIL pre_reset_fill: fill=%0d empty=%b want 7 0", rd_fill, empty);
        end
        #2;
        rd_rst = 1'b1;
        wr_ptr_grey = '0;
        #1 check_reset_outputs("async_reset_mid");
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_reset_outputs("after_release");
    endtask

    initial begin
        test_reset();
        test_fill_one();
        test_back_to_back();
        test_underflow();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
